// File: rtl/ili9341_pkg.sv
`default_nettype none
// ============================================================================
// Module : ili9341_pkg
// Brief  : Command codes, FSM state type and default geometry for ili9341_rx.
// Rev    : 1.0  initial release
// ============================================================================
package ili9341_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam int DEF_WIDTH  = 240;
    localparam int DEF_HEIGHT = 320;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_CASET  = 3'd1,
        ST_PASET  = 3'd2,
        ST_RAMWR  = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    function automatic state_t cmd_next_state(input logic [7:0] cmd);
        case (cmd)
            CMD_CASET:   return ST_CASET;
            CMD_PASET:   return ST_PASET;
            CMD_RAMWR:   return ST_RAMWR;
            CMD_SWRESET: return ST_CMD;
            default:     return ST_IGNORE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ili9341_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module : ili9341_bus_sampler
// Brief  : Registers the 8080 write bus and flags rising wr edges with cs low.
//          ILI9341_RX_SYNC_EN adds a 2-flop synchronizer ahead of the register.
// Rev    : 1.0  initial release
// ============================================================================
module ili9341_bus_sampler (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_cs,
    input  logic       in_rd,
    input  logic       in_wr,
    input  logic       in_cd,
    input  logic [7:0] in_data,
    output logic       out_strobe,
    output logic [8:0] out_byte,
    output logic       out_rd
);

    // Bus packing: {cs, rd, wr, cd, data}; idle is cs/rd/wr high.
    localparam logic [11:0] BUS_IDLE = 12'hE00;

    logic [11:0] w_bus_in;
    logic [11:0] w_bus_pre;
    logic [11:0] r_bus;
    logic        r_wr_d;

    assign w_bus_in = {in_cs, in_rd, in_wr, in_cd, in_data};

`ifdef ILI9341_RX_SYNC_EN
    logic [11:0] r_sync1;
    logic [11:0] r_sync2;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_sync1 <= BUS_IDLE;
            r_sync2 <= BUS_IDLE;
        end else begin
            r_sync1 <= w_bus_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_bus_pre = r_sync2;
`else
    assign w_bus_pre = w_bus_in;
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_bus  <= BUS_IDLE;
            r_wr_d <= 1'b1;
        end else begin
            r_bus  <= w_bus_pre;
            r_wr_d <= r_bus[9];
        end
    end

    assign out_strobe = r_bus[9] & ~r_wr_d & ~r_bus[11];
    assign out_byte   = r_bus[8:0];
    assign out_rd     = r_bus[10];

endmodule
`default_nettype wire

// File: rtl/ili9341_rx.sv
`default_nettype none
// ============================================================================
// Module : ili9341_rx
// Brief  : ILI9341 write-bus responder; decodes commands and emits pixels
//          with (x,y). Optional bus synchronizer: ILI9341_RX_SYNC_EN.
// Rev    : 1.0  initial release
// ============================================================================
module ili9341_rx
    import ili9341_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_cs,
    input  logic        in_rd,
    input  logic        in_wr,
    input  logic        in_cd,
    input  logic [7:0]  in_data,
    input  logic        in_tft_rst,
    output logic        out_cmd_valid,
    output logic [7:0]  out_cmd,
    output logic        out_px_valid,
    output logic [8:0]  out_px_x,
    output logic [8:0]  out_px_y,
    output logic [15:0] out_px_color,
    output logic        out_frame_done,
    output logic        out_sleep,
    output logic        out_disp_on,
    output logic        out_err
);

    localparam logic [8:0] EC_DEF = 9'(WIDTH - 1);
    localparam logic [8:0] EP_DEF = 9'(HEIGHT - 1);

    logic       w_strobe;
    logic [8:0] w_byte;
    logic       w_rd;

    ili9341_bus_sampler u_sampler (
        .in_clk     (in_clk),
        .in_rst     (in_rst),
        .in_cs      (in_cs),
        .in_rd      (in_rd),
        .in_wr      (in_wr),
        .in_cd      (in_cd),
        .in_data    (in_data),
        .out_strobe (w_strobe),
        .out_byte   (w_byte),
        .out_rd     (w_rd)
    );

    logic [7:0] w_data;
    logic       w_cmd_cap;
    logic       w_dat_cap;
    logic       w_hard_rst;
    logic       w_soft_rst;
    logic [8:0] w_start;
    logic [8:0] w_end;
    logic       w_win_ok;
    state_t     r_state;
    state_t     w_state_next;

    logic [8:0]  r_sc, r_ec, r_sp, r_ep, r_x, r_y;
    logic [2:0]  r_pcnt;
    logic        r_start_hi;
    logic [7:0]  r_start_lo;
    logic        r_end_hi;
    logic        r_hi_valid;
    logic [7:0]  r_hi;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd;
    logic        r_px_valid;
    logic [8:0]  r_px_x, r_px_y;
    logic [15:0] r_px_color;
    logic        r_frame_done;
    logic        r_sleep;
    logic        r_disp_on;
    logic        r_err;

    assign w_data     = w_byte[7:0];
    assign w_cmd_cap  = w_strobe & ~w_byte[8];
    assign w_dat_cap  = w_strobe &  w_byte[8];
    assign w_hard_rst = in_rst | ~in_tft_rst;
    assign w_soft_rst = w_hard_rst | (w_cmd_cap & (w_data == CMD_SWRESET));
    assign w_start    = {r_start_hi, r_start_lo};
    assign w_end      = {r_end_hi, w_data};
    assign w_win_ok   = (r_sc <= r_ec) && (r_sp <= r_ep);

    always_ff @(posedge in_clk) begin
        if (w_soft_rst) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cmd_cap) begin
            w_state_next = cmd_next_state(w_data);
        end
    end

    always_ff @(posedge in_clk) begin
        if (w_soft_rst) begin
            r_sc         <= 9'd0;
            r_ec         <= EC_DEF;
            r_sp         <= 9'd0;
            r_ep         <= EP_DEF;
            r_x          <= 9'd0;
            r_y          <= 9'd0;
            r_pcnt       <= 3'd0;
            r_start_hi   <= 1'b0;
            r_start_lo   <= 8'd0;
            r_end_hi     <= 1'b0;
            r_hi_valid   <= 1'b0;
            r_hi         <= 8'd0;
            r_px_valid   <= 1'b0;
            r_px_x       <= 9'd0;
            r_px_y       <= 9'd0;
            r_px_color   <= 16'd0;
            r_frame_done <= 1'b0;
            r_sleep      <= 1'b1;
            r_disp_on    <= 1'b0;
            r_err        <= 1'b0;
            // SWRESET still reports itself as a command.
            r_cmd_valid  <= ~w_hard_rst;
            r_cmd        <= w_hard_rst ? 8'd0 : CMD_SWRESET;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_px_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            if (!w_rd) begin
                r_err <= 1'b1;
            end
            if (w_cmd_cap) begin
                r_cmd_valid <= 1'b1;
                r_cmd       <= w_data;
                r_pcnt      <= 3'd0;
                r_hi_valid  <= 1'b0;
                case (w_data)
                    CMD_SLPOUT:  r_sleep   <= 1'b0;
                    CMD_SLPIN:   r_sleep   <= 1'b1;
                    CMD_DISPON:  r_disp_on <= 1'b1;
                    CMD_DISPOFF: r_disp_on <= 1'b0;
                    CMD_RAMWR: begin
                        r_x <= r_sc;
                        r_y <= r_sp;
                    end
                    default: ;
                endcase
            end else if (w_dat_cap) begin
                case (r_state)
                    ST_CASET, ST_PASET: begin
                        if (r_pcnt < 3'd4) begin
                            r_pcnt <= r_pcnt + 3'd1;
                        end
                        case (r_pcnt)
                            3'd0: r_start_hi <= w_data[0];
                            3'd1: r_start_lo <= w_data;
                            3'd2: r_end_hi   <= w_data[0];
                            3'd3: begin
                                if (r_state == ST_CASET) begin
                                    r_sc <= w_start;
                                    r_ec <= w_end;
                                end else begin
                                    r_sp <= w_start;
                                    r_ep <= w_end;
                                end
                                if (w_start > w_end) begin
                                    r_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!r_hi_valid) begin
                            r_hi       <= w_data;
                            r_hi_valid <= 1'b1;
                        end else begin
                            r_hi_valid <= 1'b0;
                            if (!w_win_ok) begin
                                r_err <= 1'b1;
                            end else begin
                                r_px_valid <= 1'b1;
                                r_px_x     <= r_x;
                                r_px_y     <= r_y;
                                r_px_color <= {r_hi, w_data};
                                // Raster order: wrap column, then page.
                                if (r_x == r_ec) begin
                                    r_x <= r_sc;
                                    if (r_y == r_ep) begin
                                        r_y          <= r_sp;
                                        r_frame_done <= 1'b1;
                                    end else begin
                                        r_y <= r_y + 9'd1;
                                    end
                                end else begin
                                    r_x <= r_x + 9'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_cmd_valid  = r_cmd_valid;
    assign out_cmd        = r_cmd;
    assign out_px_valid   = r_px_valid;
    assign out_px_x       = r_px_x;
    assign out_px_y       = r_px_y;
    assign out_px_color   = r_px_color;
    assign out_frame_done = r_frame_done;
    assign out_sleep      = r_sleep;
    assign out_disp_on    = r_disp_on;
    assign out_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ili9341_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_ili9341_rx
// Brief  : Directed self-checking bench for ili9341_rx (reduced panel size so
//          a full-frame wrap fits in a short run).
// Rev    : 1.0  initial release
// ============================================================================
module tb_ili9341_rx;

    localparam int W = 24;
    localparam int H = 20;

    logic        in_clk;
    logic        in_rst;
    logic        in_cs;
    logic        in_rd;
    logic        in_wr;
    logic        in_cd;
    logic [7:0]  in_data;
    logic        in_tft_rst;
    logic        out_cmd_valid;
    logic [7:0]  out_cmd;
    logic        out_px_valid;
    logic [8:0]  out_px_x;
    logic [8:0]  out_px_y;
    logic [15:0] out_px_color;
    logic        out_frame_done;
    logic        out_sleep;
    logic        out_disp_on;
    logic        out_err;

    ili9341_rx #(.WIDTH(W), .HEIGHT(H)) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_cs          (in_cs),
        .in_rd          (in_rd),
        .in_wr          (in_wr),
        .in_cd          (in_cd),
        .in_data        (in_data),
        .in_tft_rst     (in_tft_rst),
        .out_cmd_valid  (out_cmd_valid),
        .out_cmd        (out_cmd),
        .out_px_valid   (out_px_valid),
        .out_px_x       (out_px_x),
        .out_px_y       (out_px_y),
        .out_px_color   (out_px_color),
        .out_frame_done (out_frame_done),
        .out_sleep      (out_sleep),
        .out_disp_on    (out_disp_on),
        .out_err        (out_err)
    );

    int checks   = 0;
    int failures = 0;
    int stray_fd = 0;

    logic [7:0]  qcmd[$];
    logic [8:0]  qx[$];
    logic [8:0]  qy[$];
    logic [15:0] qc[$];
    logic        qf[$];

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    always @(negedge in_clk) begin
        if (out_cmd_valid) qcmd.push_back(out_cmd);
        if (out_px_valid) begin
            qx.push_back(out_px_x);
            qy.push_back(out_px_y);
            qc.push_back(out_px_color);
            qf.push_back(out_frame_done);
        end else if (out_frame_done) begin
            stray_fd++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic wbyte(input logic cd, input logic [7:0] d, input logic cs);
        @(negedge in_clk);
        in_cs   = cs;
        in_cd   = cd;
        in_data = d;
        in_wr   = 1'b0;
        @(negedge in_clk);
        in_wr   = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] d);
        wbyte(1'b0, d, 1'b0);
    endtask

    task automatic par(input logic [7:0] d);
        wbyte(1'b1, d, 1'b0);
    endtask

    task automatic clearq();
        qcmd.delete();
        qx.delete();
        qy.delete();
        qc.delete();
        qf.delete();
    endtask

    initial begin
        logic [8:0]  ex [4];
        logic [8:0]  ey [4];
        logic [15:0] ec [4];
        logic        ef [4];
        logic [15:0] k16;
        int          nfd;

        in_rst = 1'b1; in_tft_rst = 1'b1; in_cs = 1'b1; in_rd = 1'b1;
        in_wr = 1'b1; in_cd = 1'b0; in_data = 8'h00;
        tick(3);
        in_rst = 1'b0;
        tick(2);
        check("rst_sleep", out_sleep, 1);
        check("rst_disp", out_disp_on, 0);
        check("rst_err", out_err, 0);
        check("rst_cmd_valid", out_cmd_valid, 0);
        check("rst_px_valid", out_px_valid, 0);
        check("rst_frame_done", out_frame_done, 0);
        check("rst_cmd", out_cmd, 0);
        check("rst_px_color", out_px_color, 0);

        // Sleep out, display on
        cmd(8'h11); cmd(8'h29);
        tick(4);
        check("pwr_ncmd", qcmd.size(), 2);
        check("pwr_cmd0", qcmd[0], 8'h11);
        check("pwr_cmd1", qcmd[1], 8'h29);
        check("pwr_sleep", out_sleep, 0);
        check("pwr_disp", out_disp_on, 1);

        // 2x2 window
        clearq();
        cmd(8'h2A); par(8'h00); par(8'h0A); par(8'h00); par(8'h0B);
        cmd(8'h2B); par(8'h00); par(8'h14); par(8'h00); par(8'h15);
        cmd(8'h2C);
        par(8'hF8); par(8'h00); par(8'h07); par(8'hE0);
        par(8'h00); par(8'h1F); par(8'hFF); par(8'hFF);
        tick(4);
        ex = '{9'd10, 9'd11, 9'd10, 9'd11};
        ey = '{9'd20, 9'd20, 9'd21, 9'd21};
        ec = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        ef = '{1'b0, 1'b0, 1'b0, 1'b1};
        check("win_npx", qx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("win_x%0d", i), qx[i], ex[i]);
            check($sformatf("win_y%0d", i), qy[i], ey[i]);
            check($sformatf("win_c%0d", i), qc[i], ec[i]);
            check($sformatf("win_fd%0d", i), qf[i], ef[i]);
        end
        check("win_err", out_err, 0);

        // Byte with cs high must be ignored
        clearq();
        wbyte(1'b0, 8'h28, 1'b1);
        tick(4);
        check("cshi_ncmd", qcmd.size(), 0);
        check("cshi_disp", out_disp_on, 1);

        // SWRESET restores defaults and still reports the command
        cmd(8'h01);
        tick(4);
        check("swr_ncmd", qcmd.size(), 1);
        check("swr_cmd", qcmd[0], 8'h01);
        check("swr_sleep", out_sleep, 1);
        check("swr_disp", out_disp_on, 0);

        // Full default frame, colour = pixel index
        clearq();
        cmd(8'h2C);
        for (int k = 0; k < W * H; k++) begin
            k16 = 16'(k);
            par(k16[15:8]);
            par(k16[7:0]);
        end
        tick(4);
        check("frm_npx", qx.size(), W * H);
        check("frm_x23", qx[23], 23);
        check("frm_y23", qy[23], 0);
        check("frm_x24", qx[24], 0);
        check("frm_y24", qy[24], 1);
        check("frm_last_x", qx[W*H-1], W - 1);
        check("frm_last_y", qy[W*H-1], H - 1);
        check("frm_last_c", qc[W*H-1], W * H - 1);
        check("frm_last_fd", qf[W*H-1], 1);
        nfd = 0;
        foreach (qf[i]) nfd += int'(qf[i]);
        check("frm_nfd", nfd, 1);
        par(8'hBE); par(8'hEF);
        tick(4);
        check("frm_wrap_n", qx.size(), W * H + 1);
        check("frm_wrap_x", qx[W*H], 0);
        check("frm_wrap_y", qy[W*H], 0);
        check("frm_wrap_c", qc[W*H], 16'hBEEF);
        check("frm_wrap_fd", qf[W*H], 0);
        check("frm_stray_fd", stray_fd, 0);

        // Partial pixel dropped by an intervening command
        clearq();
        cmd(8'h2A); par(8'h00); par(8'h03); par(8'h00); par(8'h05);
        cmd(8'h2C); par(8'hAB); cmd(8'h00); cmd(8'h2C);
        par(8'h12); par(8'h34);
        tick(4);
        check("part_npx", qx.size(), 1);
        check("part_c", qc[0], 16'h1234);
        check("part_x", qx[0], 3);
        check("part_y", qy[0], 0);

        // Panel reset mid-CASET restores the default window
        clearq();
        cmd(8'h29);
        cmd(8'h2A); par(8'h00); par(8'h07);
        tick(1);
        @(negedge in_clk);
        in_tft_rst = 1'b0;
        tick(2);
        in_tft_rst = 1'b1;
        tick(1);
        check("tft_disp", out_disp_on, 0);
        check("tft_sleep", out_sleep, 1);
        check("tft_cmd", out_cmd, 0);
        cmd(8'h2C); par(8'h5A); par(8'hA5); par(8'h00); par(8'h01);
        tick(4);
        check("tft_npx", qx.size(), 2);
        check("tft_x0", qx[0], 0);
        check("tft_y0", qy[0], 0);
        check("tft_c0", qc[0], 16'h5AA5);
        check("tft_x1", qx[1], 1);

        // start > end flags an error and blocks pixels
        clearq();
        cmd(8'h2A); par(8'h00); par(8'h05); par(8'h00); par(8'h02);
        tick(4);
        check("bad_err", out_err, 1);
        cmd(8'h2C); par(8'h11); par(8'h22);
        tick(4);
        check("bad_npx", qx.size(), 0);
        check("bad_err_sticky", out_err, 1);

        // Read strobe low is an error
        in_rst = 1'b1;
        tick(2);
        in_rst = 1'b0;
        tick(2);
        check("rd_err_clear", out_err, 0);
        @(negedge in_clk);
        in_rd = 1'b0;
        tick(3);
        in_rd = 1'b1;
        check("rd_err", out_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ili9341_rx.md
Name: ili9341_rx

Overview:
- Responder side of the 8080-style 8-bit write bus driven by the TFT driver: decodes the ILI9341 command/parameter/pixel byte stream and emits pixel writes with (x,y) coordinates.
- Used as the display model in simulation and for on-FPGA loopback checks, where it feeds a framebuffer or checksum.
- Implements the window commands CASET and PASET, the RAMWR pixel stream, and the sleep/display state commands. All other commands are acknowledged and their parameters ignored.

Parameters:
- WIDTH, 240, column count; default column end is WIDTH-1.
- HEIGHT, 320, page count; default page end is HEIGHT-1.

Ports:
- in_clk  input  1  system clock.
- in_rst  input  1  reset; one clock, synchronous, active-high.
- in_cs  input  1  chip select, active low.
- in_rd  input  1  read strobe; must stay high (reads not supported; a low level sets out_err).
- in_wr  input  1  write strobe; data is captured on its rising edge.
- in_cd  input  1  0 = command byte, 1 = parameter/data byte.
- in_data  input  8  bus data.
- in_tft_rst  input  1  panel reset, active low.
- out_cmd_valid  output  1  one-cycle pulse per command byte.
- out_cmd  output  8  last command byte.
- out_px_valid  output  1  one-cycle pulse per completed pixel.
- out_px_x  output  9  pixel column.
- out_px_y  output  9  pixel page.
- out_px_color  output  16  RGB565 pixel value.
- out_frame_done  output  1  pulse with the pixel written at (EC,EP).
- out_sleep  output  1  1 = sleep mode.
- out_disp_on  output  1  1 = display on.
- out_err  output  1  sticky error flag.

Behaviour:
- Bus sampling: in_cs, in_rd, in_wr, in_cd and in_data are registered once.
- A byte is captured when the registered wr goes 0 to 1, registered cs = 0, and in_tft_rst = 1. Captured value is {cd,data} from the same registered sample.
- Bytes with cs high are ignored.
- Reset (in_rst=1) or in_tft_rst=0 (checked every cycle, registered):
  - state -> ST_CMD; SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1.
  - Parameter counter and pending high byte cleared.
  - All pulse outputs 0; out_cmd=0; out_px_* = 0; out_sleep=1; out_disp_on=0; out_err=0.
  - Takes effect mid-operation too; any partial pixel or parameter is discarded.
- FSM states: ST_CMD, ST_CASET, ST_PASET, ST_RAMWR, ST_IGNORE.
- Any cd=0 byte, in any state:
  - Pulses out_cmd_valid the next cycle and loads out_cmd.
  - Clears the parameter counter and drops any pending pixel high byte.
  - Next state: 0x2A -> ST_CASET, 0x2B -> ST_PASET, 0x2C -> ST_RAMWR (x=SC, y=SP), others -> ST_IGNORE.
  - Side effects: 0x11 clears out_sleep, 0x10 sets it; 0x29 sets out_disp_on, 0x28 clears it; 0x01 (SWRESET) has the same effect as in_tft_rst low, but out_cmd_valid still pulses.
- cd=1 byte in ST_CMD or ST_IGNORE: ignored.
- ST_CASET / ST_PASET parameters:
  - Bytes are start[15:8], start[7:0], end[15:8], end[7:0].
  - Registers are loaded atomically on the 4th byte, low 9 bits kept. Bytes beyond the 4th are ignored.
  - If start > end after the update, out_err is set.
- ST_RAMWR pixel assembly:
  - First byte is color[15:8], second is color[7:0].
  - out_px_valid pulses 1 cycle after the second byte's capture, with the current x, y and color.
- ST_RAMWR address advance:
  - If x==EC: x=SC, and if y==EP then y=SP and out_frame_done pulses with this pixel; otherwise y+1.
  - Otherwise x+1.
- Invalid window in ST_RAMWR (SC>EC or SP>EP): pixels are dropped (no out_px_valid), out_err is set.
- Simultaneous capture edge and in_tft_rst low: reset wins.

Optional Feature:
- ILI9341_RX_SYNC_EN.
- Defined: a 2-flop synchronizer is inserted ahead of the bus register on every bus input. Adds 2 cycles of latency to every output pulse; the receiver is then safe for a bus from an asynchronous source.
- Undefined: single register stage only; the bus must be driven from in_clk.

Decomposition:
- Package ili9341_pkg:
  - Command constants: CMD_SWRESET 0x01, SLPIN 0x10, SLPOUT 0x11, DISPOFF 0x28, DISPON 0x29, CASET 0x2A, PASET 0x2B, RAMWR 0x2C.
  - FSM state enum.
  - Default window constants.
- Sub-module ili9341_bus_sampler: optional synchronizer, bus register, rising-edge detect. Outputs a byte strobe plus {cd,data}.

Test Plan:
- Reset, then check outputs -> out_sleep=1, out_disp_on=0, out_err=0, no pulses.
- Commands 0x11 then 0x29 -> two out_cmd_valid pulses; out_sleep=0, out_disp_on=1.
- CASET 00 0A 00 0B, PASET 00 14 00 15, RAMWR, then 8 bytes F8 00 07 E0 00 1F FF FF -> pixels (10,20)=F800, (11,20)=07E0, (10,21)=001F, (11,21)=FFFF; out_frame_done with the 4th pixel.
- RAMWR at default window, then 2*240*320 bytes -> 76800 pixels, the last at (239,319) with out_frame_done; the next pixel is at (0,0).
- RAMWR, then byte AB, then command 0x00, then RAMWR, then 12 34 -> pixel 0x1234 at (SC,SP); the partial byte is dropped.
- in_tft_rst low mid-CASET after 2 params, then release, then RAMWR with 2 bytes -> pixel at (0,0) with the default window. Also cover CASET 00 05 00 02 -> out_err=1.
